// File: rtl/scoreboard_pkg.sv
// Types shared between the key->processor-id scoreboard and everything that talks to it.
`ifndef PROC_COUNT
`define PROC_COUNT 8
`endif

package scoreboard_pkg;

    localparam int KEY_W = 8;
    localparam int VAL_W = $clog2(`PROC_COUNT);

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] val;
    } entry_t;

    typedef enum logic [1:0] {
        SB_NOP   = 2'd0,
        SB_READ  = 2'd1,
        SB_WRITE = 2'd2,
        SB_FLUSH = 2'd3
    } sb_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // Strobe vector {flush, write, read}; NOP maps to no strobe.
    function automatic logic [2:0] op_strobes(sb_op_e op);
        case (op)
            SB_READ:  return 3'b001;
            SB_WRITE: return 3'b010;
            SB_FLUSH: return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/scoreboard_arbiter_if.sv
// Command/response bus between a scoreboard client (master) and the scoreboard (slave).
interface scoreboard_arbiter_if;
    import scoreboard_pkg::*;

    entry_t           o_sb_entry;
    logic             o_sb_read;
    logic             o_sb_write;
    logic             o_sb_flush;
    logic             i_sb_ack;
    logic [VAL_W-1:0] i_sb_val;
    logic             i_sb_exists;

    modport master (
        output o_sb_entry, o_sb_read, o_sb_write, o_sb_flush,
        input  i_sb_ack, i_sb_val, i_sb_exists
    );

    modport slave (
        input  o_sb_entry, o_sb_read, o_sb_write, o_sb_flush,
        output i_sb_ack, i_sb_val, i_sb_exists
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_valid
);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        o_grant = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(i_ptr) + k) % NUM_REQ);
            if (!found && i_req[idx]) begin
                found        = 1'b1;
                o_grant[idx] = 1'b1;
            end
        end
        o_valid = found;
    end

endmodule

// File: rtl/scoreboard_arbiter.sv
// Round-robin sharing of the single-ported scoreboard between NUM_REQ requesters.
// state | meaning
// IDLE  | arbitrate, latch grant/op/entry of the winner
// ISSUE | one-cycle strobe to the scoreboard (none for NOP)
// WAIT  | entry held, counting toward TIMEOUT until ack
// RESP  | one-cycle o_done to the granted requester, advance rr pointer
module scoreboard_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int KEY_W   = scoreboard_pkg::KEY_W,
    parameter int VAL_W   = scoreboard_pkg::VAL_W,
    parameter int TIMEOUT = 16
) (
    input  logic                                 i_clk,
    input  logic                                 i_rstn,
    input  logic [NUM_REQ-1:0]                   i_req,
    input  logic [NUM_REQ-1:0][1:0]              i_op,
    input  scoreboard_pkg::entry_t [NUM_REQ-1:0] i_entry,
    output logic [NUM_REQ-1:0]                   o_done,
    output logic [VAL_W-1:0]                     o_id,
    output logic                                 o_exists,
    output logic                                 o_err,
    output logic                                 o_busy,
    scoreboard_arbiter_if.master                 sb
);
    import scoreboard_pkg::*;

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    if (NUM_REQ < 2) begin : g_chk_num_req
        $error("NUM_REQ must be at least 2");
    end
    if (TIMEOUT < 2) begin : g_chk_timeout
        $error("TIMEOUT must be at least 2");
    end
    if (KEY_W + VAL_W != $bits(entry_t)) begin : g_chk_entry
        $error("KEY_W/VAL_W do not match entry_t");
    end

    arb_state_e       state_q, state_d;
    logic [PTR_W-1:0] grant_q, grant_d;
    sb_op_e           op_q, op_d;
    entry_t           entry_q, entry_d;
    logic [VAL_W-1:0] id_q, id_d;
    logic             exists_q, exists_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic               pick_valid;
    logic [PTR_W-1:0]   pick_idx;
    logic [2:0]         stb;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .i_req   (i_req),
        .i_ptr   (rr_ptr_q),
        .o_grant (pick_grant),
        .o_valid (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) pick_idx = PTR_W'(i);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            op_q     <= SB_NOP;
            entry_q  <= '0;
            id_q     <= '0;
            exists_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            op_q     <= op_d;
            entry_q  <= entry_d;
            id_q     <= id_d;
            exists_q <= exists_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        op_d     = op_q;
        entry_d  = entry_q;
        id_d     = id_q;
        exists_d = exists_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        stb      = 3'b000;
        o_done   = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    op_d    = sb_op_e'(i_op[pick_idx]);
                    entry_d = i_entry[pick_idx];
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                stb = op_strobes(op_q);
                if (op_q == SB_NOP) begin
                    err_d    = 1'b1;
                    exists_d = 1'b0;
                    id_d     = '0;
                    state_d  = ST_RESP;
                end else if (sb.i_sb_ack) begin
                    id_d     = sb.i_sb_val;
                    exists_d = sb.i_sb_exists;
                    err_d    = 1'b0;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (sb.i_sb_ack) begin
                    id_d     = sb.i_sb_val;
                    exists_d = sb.i_sb_exists;
                    err_d    = 1'b0;
                    state_d  = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    id_d     = '0;
                    exists_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RESP: begin
                o_done[grant_q] = 1'b1;
                rr_ptr_d        = PTR_W'((int'(grant_q) + 1) % NUM_REQ);
                state_d         = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign o_busy        = (state_q != ST_IDLE);
    assign o_id          = (state_q == ST_RESP) ? id_q : '0;
    assign o_exists      = (state_q == ST_RESP) && exists_q;
    assign o_err         = (state_q == ST_RESP) && err_q;
    assign sb.o_sb_entry = entry_q;
    assign sb.o_sb_read  = stb[0];
    assign sb.o_sb_write = stb[1];
    assign sb.o_sb_flush = stb[2];

endmodule

// File: tb/tb_scoreboard_arbiter.sv
// Scoreboard-style bench for scoreboard_arbiter with a behavioural scoreboard memory model.
module tb_scoreboard_arbiter;
    import scoreboard_pkg::*;

    typedef struct {
        logic [3:0] done;
        logic [2:0] id;
        logic       ex;
        logic       err;
        bit         chk_data;
    } exp_t;

    typedef struct {
        sb_op_e op;
        entry_t e;
    } log_t;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [3:0]       req;
    logic [3:0][1:0]  op;
    entry_t [3:0]     ent;
    logic [3:0]       done;
    logic [2:0]       id;
    logic             ex, err, busy;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    log_t log_q[$];

    logic [2:0] mem [256];
    bit         vld [256];
    int         ack_delay = 1;
    int         pend = 0;
    logic [2:0] pend_val;
    logic       pend_ex;
    bit         prev_stb = 1'b0;
    bit         in_txn = 1'b0;
    entry_t     last_entry;

    scoreboard_arbiter_if sb_if ();

    scoreboard_arbiter #(
        .NUM_REQ (4),
        .KEY_W   (8),
        .VAL_W   (3),
        .TIMEOUT (16)
    ) dut (
        .i_clk    (clk),
        .i_rstn   (rstn),
        .i_req    (req),
        .i_op     (op),
        .i_entry  (ent),
        .o_done   (done),
        .o_id     (id),
        .o_exists (ex),
        .o_err    (err),
        .o_busy   (busy),
        .sb       (sb_if.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t mk(logic [3:0] d, logic [2:0] i, logic e, logic r, bit c);
        exp_t x;
        x.done = d; x.id = i; x.ex = e; x.err = r; x.chk_data = c;
        return x;
    endfunction

    // Scoreboard model: executes strobes, acks after ack_delay cycles (0 = same cycle, <0 = never).
    always @(negedge clk) begin
        logic [2:0] stb;
        logic [2:0] rv;
        logic       re;
        if (!rstn) begin
            sb_if.i_sb_ack    = 1'b0;
            sb_if.i_sb_val    = '0;
            sb_if.i_sb_exists = 1'b0;
            pend     = 0;
            prev_stb = 1'b0;
            in_txn   = 1'b0;
        end else begin
            stb = {sb_if.o_sb_flush, sb_if.o_sb_write, sb_if.o_sb_read};
            sb_if.i_sb_ack = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    sb_if.i_sb_ack    = 1'b1;
                    sb_if.i_sb_val    = pend_val;
                    sb_if.i_sb_exists = pend_ex;
                end
            end
            if (stb != 3'b000) begin
                chk("strobe_onehot", $countones(stb), 1);
                chk("strobe_width", prev_stb, 0);
                rv = '0;
                re = 1'b0;
                if (stb[0]) begin
                    rv = vld[sb_if.o_sb_entry.key] ? mem[sb_if.o_sb_entry.key] : 3'd0;
                    re = vld[sb_if.o_sb_entry.key];
                    log_q.push_back('{op: SB_READ, e: sb_if.o_sb_entry});
                end else if (stb[1]) begin
                    mem[sb_if.o_sb_entry.key] = sb_if.o_sb_entry.val;
                    vld[sb_if.o_sb_entry.key] = 1'b1;
                    log_q.push_back('{op: SB_WRITE, e: sb_if.o_sb_entry});
                end else begin
                    vld[sb_if.o_sb_entry.key] = 1'b0;
                    log_q.push_back('{op: SB_FLUSH, e: sb_if.o_sb_entry});
                end
                last_entry = sb_if.o_sb_entry;
                in_txn     = 1'b1;
                if (ack_delay == 0) begin
                    sb_if.i_sb_ack    = 1'b1;
                    sb_if.i_sb_val    = rv;
                    sb_if.i_sb_exists = re;
                end else if (ack_delay > 0) begin
                    pend     = ack_delay;
                    pend_val = rv;
                    pend_ex  = re;
                end
            end else if (in_txn && busy && done == 4'b0000) begin
                chk("entry_stable", sb_if.o_sb_entry, last_entry);
            end
            if (done != 4'b0000 || !busy) in_txn = 1'b0;
            prev_stb = (stb != 3'b000);
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            chk("done_in_reset", done, 0);
        end else if (done != 4'b0000) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got %b, expected no completion at %0t", done, $time);
            end else begin
                e = exp_q.pop_front();
                chk("done_onehot", done, e.done);
                chk("err", err, e.err);
                if (e.chk_data) begin
                    chk("id", id, e.id);
                    chk("exists", ex, e.ex);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic single(input int r, input sb_op_e o, input logic [7:0] key,
                          input logic [2:0] val, input exp_t e, input int lat);
        int  n = 0;
        bit  seen = 1'b0;
        wait_idle();
        op[r]      = o;
        ent[r].key = key;
        ent[r].val = val;
        exp_q.push_back(e);
        req[r] = 1'b1;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (done[r]) seen = 1'b1;
        end
        req[r] = 1'b0;
        chk("done_seen", seen, 1);
        chk("latency", n, lat);
    endtask

    task automatic multi(input logic [3:0] mask, input int total, input bit drop_each);
        int n = 0;
        int got = 0;
        wait_idle();
        req = mask;
        while (got < total && n < 200) begin
            @(negedge clk);
            n++;
            if (done != 4'b0000) begin
                got++;
                if (drop_each) req = req & ~done;
            end
        end
        req = '0;
        chk("multi_count", got, total);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        req = '0;
        op  = '0;
        ent = '0;
        for (int k = 0; k < 256; k++) begin
            mem[k] = '0;
            vld[k] = 1'b0;
        end
        mem[2] = 3'd3;
        vld[2] = 1'b1;

        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_id", id, 0);
        chk("rst_exists", ex, 0);
        chk("rst_strobes", {sb_if.o_sb_flush, sb_if.o_sb_write, sb_if.o_sb_read}, 0);
        chk("rst_entry", sb_if.o_sb_entry, 0);
        rstn = 1'b1;

        // Round robin from rr_ptr=0 with 1011 held: 0,1,3,0.
        ack_delay = 0;
        op[0] = SB_READ;  ent[0].key = 8'd2; ent[0].val = 3'd0;
        op[1] = SB_READ;  ent[1].key = 8'd4; ent[1].val = 3'd0;
        op[3] = SB_WRITE; ent[3].key = 8'd9; ent[3].val = 3'd5;
        exp_q.push_back(mk(4'b0001, 3'd3, 1'b1, 1'b0, 1'b1));
        exp_q.push_back(mk(4'b0010, 3'd0, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(mk(4'b1000, 3'd0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(4'b0001, 3'd3, 1'b1, 1'b0, 1'b1));
        multi(4'b1011, 4, 1'b0);

        // Single READ, ack one cycle after the strobe.
        ack_delay = 1;
        log_q.delete();
        single(0, SB_READ, 8'd2, 3'd0, mk(4'b0001, 3'd3, 1'b1, 1'b0, 1'b1), 3);
        chk("read_log_n", log_q.size(), 1);
        if (log_q.size() == 1) begin
            chk("read_log_op", log_q[0].op, SB_READ);
            chk("read_log_key", log_q[0].e.key, 8'd2);
        end

        // WRITE then READ-back through different requesters.
        log_q.delete();
        single(2, SB_WRITE, 8'd8, 3'd3, mk(4'b0100, 3'd0, 1'b0, 1'b0, 1'b0), 3);
        single(1, SB_READ, 8'd8, 3'd0, mk(4'b0010, 3'd3, 1'b1, 1'b0, 1'b1), 3);
        chk("wr_log_n", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("wr_log_op0", log_q[0].op, SB_WRITE);
            chk("wr_log_val0", log_q[0].e.val, 3'd3);
            chk("wr_log_op1", log_q[1].op, SB_READ);
            chk("wr_log_key1", log_q[1].e.key, 8'd8);
        end

        // Timeout, then a normal transaction.
        ack_delay = -1;
        single(0, SB_READ, 8'd5, 3'd0, mk(4'b0001, 3'd0, 1'b0, 1'b1, 1'b1), 18);
        ack_delay = 1;
        single(3, SB_READ, 8'd8, 3'd0, mk(4'b1000, 3'd3, 1'b1, 1'b0, 1'b1), 3);

        // Ack on the last WAIT cycle wins; one cycle later is a timeout plus a spurious ack.
        ack_delay = 16;
        single(1, SB_READ, 8'd2, 3'd0, mk(4'b0010, 3'd3, 1'b1, 1'b0, 1'b1), 18);
        ack_delay = 17;
        single(2, SB_READ, 8'd2, 3'd0, mk(4'b0100, 3'd0, 1'b0, 1'b1, 1'b1), 18);

        // FLUSH, read-after-flush, NOP.
        ack_delay = 1;
        log_q.delete();
        single(0, SB_FLUSH, 8'd8, 3'd0, mk(4'b0001, 3'd0, 1'b0, 1'b0, 1'b0), 3);
        chk("flush_log_n", log_q.size(), 1);
        if (log_q.size() == 1) begin
            chk("flush_log_op", log_q[0].op, SB_FLUSH);
            chk("flush_log_key", log_q[0].e.key, 8'd8);
        end
        single(1, SB_READ, 8'd8, 3'd0, mk(4'b0010, 3'd0, 1'b0, 1'b0, 1'b1), 3);
        log_q.delete();
        single(2, SB_NOP, 8'd8, 3'd0, mk(4'b0100, 3'd0, 1'b0, 1'b1, 1'b1), 2);
        chk("nop_no_strobe", log_q.size(), 0);

        // Reset in WAIT drops the transaction and the rr pointer.
        ack_delay = -1;
        wait_idle();
        op[0] = SB_READ; ent[0].key = 8'd2;
        req[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_strobes", {sb_if.o_sb_flush, sb_if.o_sb_write, sb_if.o_sb_read}, 0);
        chk("mid_rst_entry", sb_if.o_sb_entry, 0);
        chk("mid_rst_err", err, 0);
        req = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        ack_delay = 1;
        op[1] = SB_READ; ent[1].key = 8'd2;
        op[2] = SB_READ; ent[2].key = 8'd8;
        exp_q.push_back(mk(4'b0010, 3'd3, 1'b1, 1'b0, 1'b1));
        exp_q.push_back(mk(4'b0100, 3'd0, 1'b0, 1'b0, 1'b1));
        multi(4'b0110, 2, 1'b1);

        repeat (3) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
